// File: rtl/shift_rows_stream.sv
// Streaming Rijndael ShiftRows / InvShiftRows for NB = 4..8 columns, with a
// 2-entry output FIFO decoupling both handshakes and a wrapping block counter.
module shift_rows_stream #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int W = 32 * NB;

  if (NB < 4 || NB > 8) begin : g_bad_nb
    $error("shift_rows_stream: NB must be in 4..8");
  end

  // Rijndael row rotation amounts; wide blocks use larger offsets on rows 2/3.
  function automatic int row_off(input int r, input int nb);
    case (r)
      0:       row_off = 0;
      1:       row_off = 1;
      2:       row_off = (nb == 8) ? 3 : 2;
      3:       row_off = (nb >= 7) ? 4 : 3;
      default: row_off = 0;
    endcase
  endfunction

  logic [W-1:0]     w_fwd;
  logic [W-1:0]     w_inv;
  logic [W-1:0]     w_xf;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;

  logic [W-1:0]     r_mem [2];
  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_blk_cnt;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF = row_off(r, NB);
      localparam int SF  = (c + OFF) % NB;
      localparam int SI  = (c - OFF + NB) % NB;
      assign w_fwd[W-1-32*c-8*r -: 8] = in_data[W-1-32*SF-8*r -: 8];
      assign w_inv[W-1-32*c-8*r -: 8] = in_data[W-1-32*SI-8*r -: 8];
    end
  end

  assign w_xf   = in_inv ? w_inv : w_fwd;
  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + 2'd1;
      2'b01:   w_cnt_nxt = r_count - 2'd1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  // FIFO storage, pointers, handshake flags and block counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_count     <= 2'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      r_count     <= w_cnt_nxt;
      r_in_ready  <= (w_cnt_nxt != 2'd2);
      r_out_valid <= (w_cnt_nxt != 2'd0);
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_xf;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr  <= ~r_rd_ptr;
        r_blk_cnt <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Randomised and directed self-checking bench for shift_rows_stream: an
// NB=4 instance and an NB=8 / CNT_W=4 instance against a byte-array model.
module tb_shift_rows_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         a_in_valid = 1'b0, a_in_ready, a_in_inv = 1'b0;
  logic [127:0] a_in_data = '0, a_out_data;
  logic         a_out_valid, a_out_ready = 1'b0;
  logic [15:0]  a_blk_cnt;

  logic         b_in_valid = 1'b0, b_in_ready, b_in_inv = 1'b0;
  logic [255:0] b_in_data = '0, b_out_data;
  logic         b_out_valid, b_out_ready = 1'b0;
  logic [3:0]   b_blk_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_rows_stream #(.NB(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .blk_cnt(a_blk_cnt)
  );

  shift_rows_stream #(.NB(8), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .blk_cnt(b_blk_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: unpack into S[r][c], rotate each row by its Rijndael offset, repack.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   s [4][8];
    logic [255:0] o;
    int           off, src;
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = d[32*nb-1-32*c-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      if (r == 0)      off = 0;
      else if (r == 1) off = 1;
      else if (r == 2) off = (nb == 8) ? 3 : 2;
      else             off = (nb >= 7) ? 4 : 3;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[32*nb-1-32*c-8*r -: 8] = s[r][src];
      end
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Push one block into DUT A and collect its result, with bounded waits.
  task automatic xfer_a(input logic [127:0] d, input bit inv, output logic [127:0] res);
    int t;
    a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv; a_out_ready = 1'b1;
    t = 0;
    while (!a_in_ready && t < 50) begin step(); t++; end
    if (t == 50) chk("in_ready_timeout", 0, 1);
    step();
    a_in_valid = 1'b0;
    t = 0;
    while (!a_out_valid && t < 50) begin step(); t++; end
    if (t == 50) chk("out_valid_timeout", 0, 1);
    res = a_out_data;
    step();
  endtask

  initial begin
    logic [127:0] q_a [$];
    logic [127:0] d, r1, r2, held;
    logic [255:0] d8, e8;
    int           acc, rt_bad, mdl_cnt;
    bit           hold_chk;

    // Reset state
    do_reset();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_blk_cnt", a_blk_cnt, 0);

    // FIPS-197 round 1 forward, 1-cycle latency
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_out_ready = 1'b1;
    a_in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    step();
    a_in_valid = 1'b0;
    chk("fips_latency", a_out_valid, 1);
    chk("fips_fwd", a_out_data, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    step();
    chk("fips_blk_cnt", a_blk_cnt, 1);

    xfer_a(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, r1);
    chk("fips_inv", r1, 128'hd42711aee0bf98f1b8b45de51e415230);

    // 1000 random forward-then-inverse round trips
    rt_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      d = rnd128();
      xfer_a(d, 1'b0, r1);
      if (i < 8) chk("rand_fwd", r1, ref_shift(d, 4, 1'b0));
      xfer_a(r1, 1'b1, r2);
      if (r2 !== d) rt_bad++;
    end
    chk("roundtrip_errors", rt_bad, 0);

    // NB=8 forward and inverse on DUT B
    for (int i = 0; i < 32; i++) d8[255-8*i -: 8] = 8'(i);
    e8 = ref_shift(d8, 8, 1'b0);
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = d8; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    chk("nb8_col0", b_out_data[255:224], 32'h00050e13);
    chk("nb8_fwd", b_out_data, e8);
    step();
    b_in_valid = 1'b1; b_in_inv = 1'b1; b_in_data = e8;
    step();
    b_in_valid = 1'b0;
    chk("nb8_inv", b_out_data, d8);
    step();

    // Backpressure: only two of three blocks accepted, held while stalled
    do_reset();
    q_a.delete(); acc = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_inv = i[0]; a_in_data = rnd128();
      if (a_in_ready) begin
        acc++;
        q_a.push_back(ref_shift({128'd0, a_in_data}, 4, a_in_inv));
      end
      step();
    end
    a_in_valid = 1'b0;
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", a_in_ready, 0);
    held = a_out_data;
    repeat (3) begin
      step();
      chk("bp_hold", a_out_data, held);
    end
    a_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("bp_valid", a_out_valid, 1);
      chk("bp_order", a_out_data, q_a.pop_front());
      step();
    end
    chk("bp_empty", a_out_valid, 0);
    chk("bp_blk_cnt", a_blk_cnt, 2);

    // Simultaneous push/pop at count = 1
    do_reset();
    q_a.delete();
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = rnd128();
    q_a.push_back(ref_shift({128'd0, a_in_data}, 4, 1'b0));
    step();
    a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_inv = i[0]; a_in_data = rnd128();
      chk("sim_in_ready", a_in_ready, 1);
      chk("sim_out_valid", a_out_valid, 1);
      chk("sim_data", a_out_data, q_a.pop_front());
      q_a.push_back(ref_shift({128'd0, a_in_data}, 4, a_in_inv));
      step();
    end
    a_in_valid = 1'b0;
    chk("sim_blk_cnt", a_blk_cnt, 10);

    // Reset mid-stream clears state without a clock edge
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = rnd128();
    repeat (2) step();
    a_in_valid = 1'b0;
    chk("mid_full", a_in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", a_out_valid, 0);
    chk("mid_in_ready", a_in_ready, 1);
    chk("mid_blk_cnt", a_blk_cnt, 0);
    #1;
    rst_n = 1'b1;
    step();

    // CNT_W = 4 wrap: 17 blocks leave blk_cnt at 1
    do_reset();
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_inv = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b_in_data = {rnd128(), rnd128()};
      step();
    end
    b_in_valid = 1'b0;
    repeat (2) step();
    chk("wrap_blk_cnt", b_blk_cnt, 1);

    // Random traffic on DUT A against a queue scoreboard
    do_reset();
    q_a.delete(); mdl_cnt = 0; hold_chk = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      chk("rnd_out_valid", a_out_valid, q_a.size() != 0);
      chk("rnd_in_ready", a_in_ready, q_a.size() != 2);
      if (hold_chk) chk("rnd_hold", a_out_data, held);
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_inv    = $urandom_range(0, 1);
      a_in_data   = rnd128();
      a_out_ready = ($urandom_range(0, 2) != 0);
      hold_chk = 1'b0;
      if (a_out_valid && a_out_ready) begin
        chk("rnd_data", a_out_data, q_a.pop_front());
        mdl_cnt++;
      end else if (a_out_valid) begin
        hold_chk = 1'b1;
        held = a_out_data;
      end
      if (a_in_valid && a_in_ready)
        q_a.push_back(ref_shift({128'd0, a_in_data}, 4, a_in_inv));
      step();
    end
    a_in_valid = 1'b0;
    chk("rnd_blk_cnt", a_blk_cnt, mdl_cnt[15:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
